// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: FSM states, key codes,
// and the keypad matrix decode helpers.
package atm_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned ROW_W = 4;
    localparam int unsigned COL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        ACT,
        WAIT_RELEASE,
        DONE
    } state_t;

    localparam logic [KEY_W-1:0] KEY_0    = 4'd0;
    localparam logic [KEY_W-1:0] KEY_1    = 4'd1;
    localparam logic [KEY_W-1:0] KEY_2    = 4'd2;
    localparam logic [KEY_W-1:0] KEY_3    = 4'd3;
    localparam logic [KEY_W-1:0] KEY_4    = 4'd4;
    localparam logic [KEY_W-1:0] KEY_5    = 4'd5;
    localparam logic [KEY_W-1:0] KEY_6    = 4'd6;
    localparam logic [KEY_W-1:0] KEY_7    = 4'd7;
    localparam logic [KEY_W-1:0] KEY_8    = 4'd8;
    localparam logic [KEY_W-1:0] KEY_9    = 4'd9;
    localparam logic [KEY_W-1:0] KEY_CLR  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_BS   = 4'hB;
    localparam logic [KEY_W-1:0] KEY_ENT  = 4'hC;
    localparam logic [KEY_W-1:0] KEY_NONE = 4'hF;

    // Index of the lowest active-low row; 0 when no row is low.
    function automatic logic [1:0] low_row(input logic [ROW_W-1:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROW_W - 1; i >= 0; i--) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Active-low column drive pattern for a column index.
    function automatic logic [COL_W-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Matrix position to key code; B, C, D and "no key" map to KEY_NONE.
    function automatic logic [KEY_W-1:0] key_decode(input logic [ROW_W-1:0] pat,
                                                    input logic [1:0] col_idx);
        logic [KEY_W-1:0] key;
        key = KEY_NONE;
        if (pat != 4'hF) begin
            case ({low_row(pat), col_idx})
                4'h0:    key = KEY_1;
                4'h1:    key = KEY_2;
                4'h2:    key = KEY_3;
                4'h3:    key = KEY_CLR;
                4'h4:    key = KEY_4;
                4'h5:    key = KEY_5;
                4'h6:    key = KEY_6;
                4'h8:    key = KEY_7;
                4'h9:    key = KEY_8;
                4'hA:    key = KEY_9;
                4'hC:    key = KEY_BS;
                4'hD:    key = KEY_0;
                4'hE:    key = KEY_ENT;
                default: key = KEY_NONE;
            endcase
        end
        return key;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Column dwell divider: one-cycle tick every SCAN_DIV cycles while run is high.
// Dropping run restarts the dwell from zero.
module scan_timer #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned DIV   = (SCAN_DIV < 1) ? 1 : SCAN_DIV;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Dwell counter wraps at its terminal count, so it never overflows.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = run && (cnt == LAST);

endmodule

// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce and a BCD digit entry buffer for the ATM
// numeric fields (account, PIN, amount). One action per physical key press.
module keypad_digit_entry
    import atm_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DEB_SAMPLES = 4,
    parameter int unsigned MAX_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [3:0]              max_len,
    input  logic                    ack,
    input  logic [3:0]              row,
    output logic [3:0]              col,
    output logic [4*MAX_DIGITS-1:0] value,
    output logic [3:0]              count,
    output logic                    done,
    output logic                    busy_done
);

    localparam int unsigned VAL_W = 4 * MAX_DIGITS;
    localparam int unsigned DEB_N = (DEB_SAMPLES < 1) ? 1 : DEB_SAMPLES;
    localparam int unsigned DEB_W = $clog2(DEB_N + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t           state;
    logic [1:0]       col_idx;
    logic [3:0]       key_row;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;

    logic             tick_c;
    logic             timer_run_c;
    logic [3:0]       limit_c;
    logic [3:0]       key_c;
    logic [1:0]       col_next_c;

    // Two-flop synchronizer on the asynchronous keypad rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign timer_run_c = enable &&
                         ((state == SCAN) || (state == DEBOUNCE) || (state == WAIT_RELEASE));
    assign limit_c     = ((max_len == 4'd0) || (max_len > MAX_CNT)) ? MAX_CNT : max_len;
    assign key_c       = key_decode(key_row, col_idx);
    assign col_next_c  = col_idx + 2'd1;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run_c),
        .tick_c (tick_c)
    );

    // Scan / debounce / entry FSM; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state     <= IDLE;
            col       <= 4'hF;
            col_idx   <= 2'd0;
            key_row   <= 4'hF;
            deb_cnt   <= '0;
            value     <= '0;
            count     <= 4'd0;
            done      <= 1'b0;
            busy_done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= SCAN;
                    col_idx   <= 2'd0;
                    col       <= col_drive(2'd0);
                    deb_cnt   <= '0;
                    value     <= '0;
                    count     <= 4'd0;
                    busy_done <= 1'b0;
                end
                SCAN: begin
                    if (tick_c) begin
                        if (row_sync != 4'hF) begin
                            key_row <= row_sync;
                            deb_cnt <= DEB_W'(1);
                            state   <= (DEB_N == 1) ? ACT : DEBOUNCE;
                        end else begin
                            col_idx <= col_next_c;
                            col     <= col_drive(col_next_c);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick_c) begin
                        if (row_sync != key_row) begin
                            deb_cnt <= '0;
                            col_idx <= col_next_c;
                            col     <= col_drive(col_next_c);
                            state   <= SCAN;
                        end else if (deb_cnt == DEB_LAST) begin
                            state <= ACT;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                end
                ACT: begin
                    state   <= WAIT_RELEASE;
                    deb_cnt <= '0;
                    if (key_c <= KEY_9) begin
                        if (count < limit_c) begin
                            value <= (value << 4) | VAL_W'(key_c);
                            count <= count + 4'd1;
                        end
                    end else if (key_c == KEY_BS) begin
                        if (count != 4'd0) begin
                            value <= value >> 4;
                            count <= count - 4'd1;
                        end
                    end else if (key_c == KEY_CLR) begin
                        value <= '0;
                        count <= 4'd0;
                    end else if ((key_c == KEY_ENT) && (count != 4'd0)) begin
                        state     <= DONE;
                        col       <= 4'hF;
                        done      <= 1'b1;
                        busy_done <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (tick_c) begin
                        if (row_sync == 4'hF) begin
                            if (deb_cnt == DEB_LAST) begin
                                deb_cnt <= '0;
                                col_idx <= col_next_c;
                                col     <= col_drive(col_next_c);
                                state   <= SCAN;
                            end else begin
                                deb_cnt <= deb_cnt + DEB_W'(1);
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    busy_done <= 1'b1;
                    col       <= 4'hF;
                    if (ack) begin
                        state     <= IDLE;
                        value     <= '0;
                        count     <= 4'd0;
                        busy_done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    col   <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with a behavioural 4x4 key matrix.
module tb_keypad_digit_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  max_len;
    logic        ack;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] value;
    logic [3:0]  count;
    logic        done;
    logic        busy_done;

    logic [15:0] keys = 16'h0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    keypad_digit_entry #(
        .SCAN_DIV    (4),
        .DEB_SAMPLES (2),
        .MAX_DIGITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .max_len   (max_len),
        .ack       (ack),
        .row       (row),
        .col       (col),
        .value     (value),
        .count     (count),
        .done      (done),
        .busy_done (busy_done)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key (bit r*4+c) pulls row r low when column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // Count done pulses.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press_mask(input logic [15:0] m);
        keys = m;
        repeat (60) @(negedge clk);
        keys = 16'h0;
        repeat (60) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        logic [15:0] m;
        m = 16'h0;
        m[r*4+c] = 1'b1;
        press_mask(m);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n;
        n = 0;
        while (col !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", 32'(col), 32'(want));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ack = 1'b0; max_len = 4'd4;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'hF);
        check("rst_value", value, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy_done), 32'h0);

        // Reset wins over enable.
        enable = 1'b1;
        @(negedge clk);
        check("rst_over_en_col", 32'(col), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("scan_start_col0", 32'(col), 32'hE);

        // 1 2 3 4 then enter.
        press(0, 0); press(0, 1); press(0, 2); press(1, 0);
        check("seq_value", value, 32'h1234);
        check("seq_count", 32'(count), 32'd4);
        press(3, 2);
        check("ent_done_pulses", 32'(done_cnt), 32'd1);
        check("ent_busy", 32'(busy_done), 32'h1);
        check("ent_value", value, 32'h1234);
        check("ent_col", 32'(col), 32'hF);
        press(2, 2);
        check("done_key_ignored", value, 32'h1234);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_value", value, 32'h0);
        check("ack_count", 32'(count), 32'h0);
        check("ack_busy", 32'(busy_done), 32'h0);

        // Bounced key 5: pressed for the scan sample, released for the debounce sample.
        max_len = 4'd0;
        wait_col(4'hD);
        keys = 16'h0020;
        repeat (3) @(negedge clk);
        keys = 16'h0;
        repeat (4) @(negedge clk);
        keys = 16'h0020;
        repeat (2) @(negedge clk);
        check("bounce_reject", 32'(count), 32'd0);
        repeat (60) @(negedge clk);
        keys = 16'h0;
        repeat (60) @(negedge clk);
        check("bounce_value", value, 32'h5);
        check("bounce_count", 32'(count), 32'd1);

        // Limit of 2 digits, backspace, clear, enter on empty buffer.
        press(0, 3);
        check("clr_count", 32'(count), 32'd0);
        max_len = 4'd2;
        press(2, 0); press(2, 1); press(2, 2);
        check("lim_value", value, 32'h78);
        check("lim_count", 32'(count), 32'd2);
        press(3, 0);
        check("bs_value", value, 32'h7);
        check("bs_count", 32'(count), 32'd1);
        press(0, 3);
        check("clr2_count", 32'(count), 32'd0);
        check("clr2_value", value, 32'h0);
        press(3, 2);
        check("empty_ent_done", 32'(done_cnt), 32'd1);
        check("empty_ent_busy", 32'(busy_done), 32'h0);

        // Rows 1 and 3 low together in column 1: lowest row (key 5) wins once.
        max_len = 4'd0;
        press_mask(16'h2020);
        check("multi_value", value, 32'h5);
        check("multi_count", 32'(count), 32'd1);

        // Reset during debounce of key 9.
        wait_col(4'hB);
        keys = 16'h0400;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_deb_col", 32'(col), 32'hF);
        check("rst_deb_value", value, 32'h0);
        check("rst_deb_count", 32'(count), 32'd0);
        keys = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rst_deb_no_digit", 32'(count), 32'd0);
        check("rst_deb_no_done", 32'(done_cnt), 32'd1);

        // Enable dropped while holding a confirmed entry.
        press(0, 0); press(0, 1); press(3, 2);
        check("en_done_pulses", 32'(done_cnt), 32'd2);
        check("en_busy", 32'(busy_done), 32'h1);
        check("en_value", value, 32'h12);
        enable = 1'b0;
        @(negedge clk);
        check("dis_busy", 32'(busy_done), 32'h0);
        check("dis_value", value, 32'h0);
        check("dis_count", 32'(count), 32'd0);
        check("dis_col", 32'(col), 32'hF);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("reen_col0", 32'(col), 32'hE);
        check("reen_done_pulses", 32'(done_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_digit_entry.md
KEYPAD_DIGIT_ENTRY -- requirements
Module: keypad_digit_entry

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per column dwell (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEB_SAMPLES, default 4, meaning consecutive identical samples needed for press or release acceptance.
REQ-003 SHALL have parameter MAX_DIGITS, default 8, meaning BCD buffer depth in digits.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  high while the ATM state expects numeric entry (account, PIN, amount); low idles the block.
REQ-007 max_len  input  4  digit limit for the current field; 0 or >MAX_DIGITS means MAX_DIGITS.
REQ-008 ack  input  1  consumer has taken value; releases DONE.
REQ-009 row  input  4  keypad rows, active-low, externally pulled up.
REQ-010 col  output  4  keypad column drive, active-low, exactly one low while scanning.
REQ-011 value  output  4*MAX_DIGITS  BCD digits, newest in [3:0].
REQ-012 count  output  4  number of digits entered.
REQ-013 done  output  1  one-cycle pulse when entry is confirmed.
REQ-014 busy_done  output  1  high while in DONE and holding value.

Function
REQ-015 Key map by (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; digits edit, A=clear, *=backspace, #=enter; B, C, D ignored.
REQ-016 FSM states SHALL be IDLE, SCAN, DEBOUNCE, ACT, WAIT_RELEASE, DONE.
REQ-017 IDLE: col=4'b1111, value=0, count=0; enable=1 -> SCAN with col index 0.
REQ-018 SCAN: drive column index c low for SCAN_DIV cycles, sample row on the last cycle; if any row is low -> DEBOUNCE latching (c, row pattern); else advance c modulo 4.
REQ-019 Multiple rows low in one column: the lowest row index wins; other columns are not examined until release.
REQ-020 DEBOUNCE: hold column c, resample every SCAN_DIV cycles; DEB_SAMPLES identical patterns in a row -> ACT; any differing sample -> SCAN at c+1.
REQ-021 ACT (one cycle): a digit with count<limit gives value = {value[lower], d}, count+1; a digit at the limit is ignored; * with count>0 gives value >> 4, count-1, else no-op; A gives value=0, count=0; # with count>0 -> DONE, else no-op; then -> WAIT_RELEASE, except on a valid #.
REQ-022 WAIT_RELEASE: hold column c until DEB_SAMPLES consecutive all-high samples, then -> SCAN at c+1; this yields exactly one action per physical press.
REQ-023 DONE: done=1 on the entry cycle only; busy_done=1; value/count frozen; keys ignored, col=4'b1111; ack=1 -> IDLE, buffer cleared.
REQ-024 enable=0 in any state SHALL force IDLE on the next edge and clear value/count; this has priority over ack and key actions.
REQ-025 Dwell and debounce counters SHALL saturate/wrap only at their terminal count; no counter SHALL overflow for any legal parameter.
REQ-026 row SHALL pass through a 2-flop synchronizer before use; sample latency is counted after synchronization.

Reset
REQ-027 rst=1 SHALL give state IDLE, col=4'b1111, value=0, count=0, done=0, busy_done=0, and all counters 0, taking priority over enable and ack.
REQ-028 Reset mid-debounce or mid-DONE SHALL discard the pending key and the buffer; no done pulse SHALL follow.

Structure
REQ-029 Key-code constants (KEY_0..KEY_9, KEY_CLR, KEY_BS, KEY_ENT, KEY_NONE) and the FSM state encoding SHALL live in shared package atm_pkg.
REQ-030 The column dwell divider SHALL be sub-module scan_timer (output: one-cycle tick every SCAN_DIV cycles, restartable).
REQ-031 The (row,col)->key decode SHALL be a combinational function in atm_pkg.

Verification (SCAN_DIV=4, DEB_SAMPLES=2)
REQ-032 Press 1, 2, 3, 4, then #, with max_len=4 -> value[15:0]=16'h1234, count=4, done pulses once, busy_done=1; ack -> value=0.
REQ-033 Bounce key 5 (press 1 sample, release 1, press held) -> exactly one digit 5 accepted after 2 stable samples.
REQ-034 max_len=2: press 7, 8, 9 -> value=8'h78, count=2; * -> value=4'h7, count=1; A -> count=0; # -> no done.
REQ-035 Rows r1 and r3 both low in col1 -> key 5 accepted (lowest row), single action.
REQ-036 rst asserted during DEBOUNCE of key 9 -> outputs at reset values next edge; no digit recorded.
REQ-037 enable dropped in DONE before ack -> IDLE, value=0, busy_done=0; re-enable resumes scanning at col0.
